// File: rtl/mdio_phy_ctrl_if.sv
// Host register-access port of mdio_phy_ctrl: a level request held until a one-cycle ack.
// master = host side, slave = controller side.
interface mdio_phy_ctrl_if;
    logic        usr_req;
    logic        usr_r_w;
    logic [4:0]  usr_reg_add;
    logic [15:0] usr_wdata;
    logic        usr_ack;
    logic [15:0] usr_rdata;

    modport master (
        output usr_req, usr_r_w, usr_reg_add, usr_wdata,
        input  usr_ack, usr_rdata
    );

    modport slave (
        input  usr_req, usr_r_w, usr_reg_add, usr_wdata,
        output usr_ack, usr_rdata
    );
endinterface

// File: rtl/mdio_phy_ctrl.sv
// PHY bring-up sequencer and arbiter in front of the mdio engine (soft reset, 100M FD config,
// then host frames and, with MDIO_LINK_POLL_EN defined, periodic reg 1 link-status polls).
module mdio_phy_ctrl #(
    parameter logic [4:0] PHY_ADDR      = 5'd0,
    parameter int         FRAME_CYCLES  = 1280,
    parameter int         RESET_WAIT    = 500_000,
    parameter int         POLL_INTERVAL = 50_000_000
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    mdio_phy_ctrl_if.slave     usr,
    output logic               init_done,
    output logic               link_up,
    output logic               link_chg,
    output logic               start_flag,
    output logic               r_w,
    output logic [4:0]         phy_add,
    output logic [4:0]         reg_add,
    output logic [15:0]        write_reg_data,
    input  logic [15:0]        read_reg_data
);

    localparam int CNT_MAX = (FRAME_CYCLES > RESET_WAIT) ? FRAME_CYCLES : RESET_WAIT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {S_INIT_RST, S_RST_WAIT, S_INIT_CFG, S_IDLE, S_BUSY} state_t;
    typedef enum logic [1:0] {K_INIT, K_CFG, K_HOST, K_POLL} kind_t;

    state_t             state_q, state_d, ret_q, ret_d;
    kind_t              kind_q, kind_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_flag_q, start_flag_d;
    logic               r_w_q, r_w_d;
    logic [4:0]         reg_add_q, reg_add_d;
    logic [15:0]        wdata_q, wdata_d;
    logic               usr_ack_q, usr_ack_d;
    logic [15:0]        usr_rdata_q, usr_rdata_d;
    logic               init_done_q, init_done_d;

`ifdef MDIO_LINK_POLL_EN
    localparam int TMR_W = $clog2(POLL_INTERVAL);
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               poll_pending_q, poll_pending_d;
    logic               link_up_q, link_up_d;
    logic               link_chg_q, link_chg_d;
`endif

    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        kind_d       = kind_q;
        cnt_d        = cnt_q;
        start_flag_d = 1'b0;
        r_w_d        = r_w_q;
        reg_add_d    = reg_add_q;
        wdata_d      = wdata_q;
        usr_ack_d    = 1'b0;
        usr_rdata_d  = usr_rdata_q;
        init_done_d  = init_done_q;
`ifdef MDIO_LINK_POLL_EN
        timer_d        = timer_q;
        poll_pending_d = poll_pending_q;
        link_up_d      = link_up_q;
        link_chg_d     = 1'b0;
`endif
        case (state_q)
            S_INIT_RST: begin
                start_flag_d = 1'b1;
                r_w_d        = 1'b0;
                reg_add_d    = 5'd0;
                wdata_d      = 16'h8000;
                kind_d       = K_INIT;
                ret_d        = S_RST_WAIT;
                cnt_d        = CNT_W'(1);
                state_d      = S_BUSY;
            end
            S_RST_WAIT: begin
                if (cnt_q == CNT_W'(RESET_WAIT)) state_d = S_INIT_CFG;
                else                             cnt_d   = cnt_q + CNT_W'(1);
            end
            S_INIT_CFG: begin
                start_flag_d = 1'b1;
                r_w_d        = 1'b0;
                reg_add_d    = 5'd0;
                wdata_d      = 16'h2100;
                kind_d       = K_CFG;
                ret_d        = S_IDLE;
                cnt_d        = CNT_W'(1);
                state_d      = S_BUSY;
            end
            S_IDLE: begin
                if (usr.usr_req) begin
                    start_flag_d = 1'b1;
                    r_w_d        = usr.usr_r_w;
                    reg_add_d    = usr.usr_reg_add;
                    wdata_d      = usr.usr_wdata;
                    kind_d       = K_HOST;
                    ret_d        = S_IDLE;
                    cnt_d        = CNT_W'(1);
                    state_d      = S_BUSY;
                end
`ifdef MDIO_LINK_POLL_EN
                else if (poll_pending_q) begin
                    start_flag_d   = 1'b1;
                    r_w_d          = 1'b1;
                    reg_add_d      = 5'd1;
                    wdata_d        = 16'h0000;
                    kind_d         = K_POLL;
                    ret_d          = S_IDLE;
                    cnt_d          = CNT_W'(1);
                    state_d        = S_BUSY;
                    poll_pending_d = 1'b0;
                end
`endif
            end
            S_BUSY: begin
                if (cnt_q == CNT_W'(FRAME_CYCLES)) begin
                    case (kind_q)
                        K_CFG:  init_done_d = 1'b1;
                        K_HOST: begin
                            usr_ack_d = 1'b1;
                            if (r_w_q) usr_rdata_d = read_reg_data;
                        end
`ifdef MDIO_LINK_POLL_EN
                        K_POLL: begin
                            link_up_d  = read_reg_data[2];
                            link_chg_d = read_reg_data[2] ^ link_up_q;
                        end
`endif
                        default: ;
                    endcase
                    // Preloaded so RST_WAIT counts 1..RESET_WAIT from its first cycle.
                    cnt_d   = CNT_W'(1);
                    state_d = ret_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_INIT_RST;
        endcase
`ifdef MDIO_LINK_POLL_EN
        // Placed after the issue logic so a fresh expiry wins over a same-cycle clear.
        if (init_done_q) begin
            if (timer_q == TMR_W'(POLL_INTERVAL - 1)) begin
                timer_d        = '0;
                poll_pending_d = 1'b1;
            end else begin
                timer_d = timer_q + TMR_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q      <= S_INIT_RST;
            ret_q        <= S_INIT_RST;
            kind_q       <= K_INIT;
            cnt_q        <= '0;
            start_flag_q <= 1'b0;
            r_w_q        <= 1'b0;
            reg_add_q    <= 5'd0;
            wdata_q      <= 16'h0000;
            usr_ack_q    <= 1'b0;
            usr_rdata_q  <= 16'h0000;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            kind_q       <= kind_d;
            cnt_q        <= cnt_d;
            start_flag_q <= start_flag_d;
            r_w_q        <= r_w_d;
            reg_add_q    <= reg_add_d;
            wdata_q      <= wdata_d;
            usr_ack_q    <= usr_ack_d;
            usr_rdata_q  <= usr_rdata_d;
            init_done_q  <= init_done_d;
        end
    end

`ifdef MDIO_LINK_POLL_EN
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            timer_q        <= '0;
            poll_pending_q <= 1'b0;
            link_up_q      <= 1'b0;
            link_chg_q     <= 1'b0;
        end else begin
            timer_q        <= timer_d;
            poll_pending_q <= poll_pending_d;
            link_up_q      <= link_up_d;
            link_chg_q     <= link_chg_d;
        end
    end
    assign link_up  = link_up_q;
    assign link_chg = link_chg_q;
`else
    assign link_up  = 1'b0;
    assign link_chg = 1'b0;
`endif

    assign start_flag     = start_flag_q;
    assign r_w            = r_w_q;
    assign phy_add        = PHY_ADDR;
    assign reg_add        = reg_add_q;
    assign write_reg_data = wdata_q;
    assign init_done      = init_done_q;
    assign usr.usr_ack    = usr_ack_q;
    assign usr.usr_rdata  = usr_rdata_q;

endmodule

// File: tb/tb_mdio_phy_ctrl.sv
// Scoreboard bench for mdio_phy_ctrl: stimulus pushes expected frames, a monitor checks each
// start_flag, field stability and completion effects. Poll scenarios need MDIO_LINK_POLL_EN.
module tb_mdio_phy_ctrl;
    localparam int         FRAME = 8;
    localparam int         RWAIT = 16;
    localparam int         POLL  = 100;
    localparam logic [4:0] PADDR = 5'd3;

    localparam int K_INIT = 0, K_CFG = 1, K_HOST = 2, K_POLL = 3;

    typedef struct {
        logic        r_w;
        logic [4:0]  reg_add;
        logic [15:0] wdata;
        int          kind;
        int          cyc;      // expected issue cycle, -1 = any
        logic [15:0] rdata;    // host read result
        logic        lu;       // poll: expected link_up
        logic        lc;       // poll: expected link_chg
    } frame_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        init_done, link_up, link_chg, start_flag, r_w;
    logic [4:0]  phy_add, reg_add;
    logic [15:0] write_reg_data;
    logic [15:0] read_reg_data = 16'h0000;

    mdio_phy_ctrl_if u_if ();

    mdio_phy_ctrl #(
        .PHY_ADDR(PADDR), .FRAME_CYCLES(FRAME), .RESET_WAIT(RWAIT), .POLL_INTERVAL(POLL)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .usr(u_if.slave),
        .init_done(init_done), .link_up(link_up), .link_chg(link_chg),
        .start_flag(start_flag), .r_w(r_w), .phy_add(phy_add), .reg_add(reg_add),
        .write_reg_data(write_reg_data), .read_reg_data(read_reg_data)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc;
    always @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) cyc <= 0;
        else            cyc <= cyc + 1;

    int     n_cmp = 0;
    int     n_err = 0;
    frame_t exp_q[$];
    bit     active;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %h required %h", name, cyc, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s at cycle %0d: got timeout required event", name, cyc);
    endtask

    function automatic frame_t mk(input logic rw, input logic [4:0] ra, input logic [15:0] wd,
                                  input int kind, input int c, input logic [15:0] rd,
                                  input logic lu, input logic lc);
        frame_t f;
        f.r_w = rw; f.reg_add = ra; f.wdata = wd; f.kind = kind; f.cyc = c;
        f.rdata = rd; f.lu = lu; f.lc = lc;
        return f;
    endfunction

    // Monitor / scoreboard
    frame_t      cur;
    int          start_cyc;
    logic        exp_init, exp_lu;
    logic [15:0] hold_rd;
    initial begin
        active = 0; exp_init = 0; exp_lu = 0; hold_rd = 16'h0;
        forever begin
            @(posedge sys_clk); #1;
            if (!sys_rst_n) begin
                active = 0; exp_init = 0; exp_lu = 0; hold_rd = 16'h0;
            end else begin
                if (active && (cyc - start_cyc) == FRAME) begin
                    active = 0;
                    chk("ack_at_done", u_if.usr_ack, (cur.kind == K_HOST));
                    if (cur.kind == K_HOST) begin
                        if (cur.r_w) hold_rd = cur.rdata;
                        chk("usr_rdata", u_if.usr_rdata, hold_rd);
                    end
                    if (cur.kind == K_CFG) exp_init = 1'b1;
                    if (cur.kind == K_POLL) begin
                        exp_lu = cur.lu;
                        chk("link_chg_done", link_chg, cur.lc);
                    end else begin
                        chk("link_chg_quiet", link_chg, 1'b0);
                    end
                    $display("frame done kind=%0d reg=%0d r_w=%0b wdata=%h start=%0d end=%0d",
                             cur.kind, cur.reg_add, cur.r_w, cur.wdata, start_cyc, cyc);
                end else if (active) begin
                    chk("start_in_frame", start_flag, 1'b0);
                    chk("r_w_stable", r_w, cur.r_w);
                    chk("reg_add_stable", reg_add, cur.reg_add);
                    if (cur.kind != K_POLL) chk("wdata_stable", write_reg_data, cur.wdata);
                    chk("ack_early", u_if.usr_ack, 1'b0);
                    chk("link_chg_in_frame", link_chg, 1'b0);
                end else begin
                    chk("ack_spurious", u_if.usr_ack, 1'b0);
                    chk("link_chg_idle", link_chg, 1'b0);
                end
                chk("init_done", init_done, exp_init);
                chk("link_up", link_up, exp_lu);
                if (start_flag && !active) begin
                    if (exp_q.size() == 0) begin
                        fail("unexpected_frame");
                    end else begin
                        cur = exp_q.pop_front();
                        chk("issue_r_w", r_w, cur.r_w);
                        chk("issue_reg_add", reg_add, cur.reg_add);
                        if (cur.kind != K_POLL) chk("issue_wdata", write_reg_data, cur.wdata);
                        chk("phy_add", phy_add, PADDR);
                        if (cur.cyc >= 0) chk("issue_cycle", cyc, cur.cyc);
                        start_cyc = cyc;
                        active    = 1;
                    end
                end
            end
        end
    end

    task automatic wait_until(input int c);
        while (cyc < c) begin @(posedge sys_clk); #1; end
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while ((exp_q.size() != 0 || active) && k < budget) begin
            @(posedge sys_clk); #1; k++;
        end
        if (exp_q.size() != 0 || active) fail("drain");
    endtask

    task automatic do_host(input logic rw, input logic [4:0] ra, input logic [15:0] wd,
                           input logic [15:0] rd, input int exp_cyc);
        bit got = 0;
        exp_q.push_back(mk(rw, ra, wd, K_HOST, exp_cyc, rd, 1'b0, 1'b0));
        u_if.usr_r_w = rw; u_if.usr_reg_add = ra; u_if.usr_wdata = wd;
        u_if.usr_req = 1'b1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(posedge sys_clk); #1;
            if (u_if.usr_ack) got = 1;
        end
        if (!got) fail("usr_ack");
        u_if.usr_req = 1'b0;
    endtask

    task automatic chk_reset_vals();
        chk("rst_start_flag", start_flag, 1'b0);
        chk("rst_usr_ack", u_if.usr_ack, 1'b0);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_link_up", link_up, 1'b0);
        chk("rst_link_chg", link_chg, 1'b0);
        chk("rst_r_w", r_w, 1'b0);
        chk("rst_reg_add", reg_add, 5'd0);
        chk("rst_wdata", write_reg_data, 16'h0);
        chk("rst_usr_rdata", u_if.usr_rdata, 16'h0);
        chk("rst_phy_add", phy_add, PADDR);
    endtask

    task automatic release_reset();
        exp_q.push_back(mk(1'b0, 5'd0, 16'h8000, K_INIT, 1, 16'h0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b0, 5'd0, 16'h2100, K_CFG, 1 + FRAME + RWAIT + 1, 16'h0, 1'b0, 1'b0));
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        #100_000;
        $display("FAIL watchdog at cycle %0d: got no finish required finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.usr_req = 1'b0; u_if.usr_r_w = 1'b0; u_if.usr_reg_add = 5'd0; u_if.usr_wdata = 16'h0;
        repeat (3) @(posedge sys_clk);
        #1 chk_reset_vals();
        release_reset();

        // Host write requested during init: held, served first at cycle 35.
        wait_until(2);
        do_host(1'b0, 5'd4, 16'h01E1, 16'h0, 1 + FRAME + RWAIT + 1 + FRAME + 1);
        read_reg_data = 16'h0022;
        do_host(1'b1, 5'd2, 16'h0000, 16'h0022, -1);
        read_reg_data = 16'h0000;
        do_host(1'b0, 5'd7, 16'hA5A5, 16'h0, -1);
        drain(50);
        chk("rdata_retained", u_if.usr_rdata, 16'h0022);

`ifdef MDIO_LINK_POLL_EN
        // Poll timer starts at init_done (cycle 34): expiries at 134, 234, 334, 434.
        read_reg_data = 16'h0004;
        exp_q.push_back(mk(1'b1, 5'd1, 16'h0, K_POLL, 135, 16'h0, 1'b1, 1'b1));
        drain(200);
        exp_q.push_back(mk(1'b1, 5'd1, 16'h0, K_POLL, 235, 16'h0, 1'b1, 1'b0));
        drain(200);
        read_reg_data = 16'h0000;
        exp_q.push_back(mk(1'b1, 5'd1, 16'h0, K_POLL, 335, 16'h0, 1'b0, 1'b1));
        drain(200);
        // Host request and poll pending together: host at 435, poll right after at 444.
        wait_until(434);
        exp_q.push_back(mk(1'b0, 5'd9, 16'h1234, K_HOST, 435, 16'h0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b1, 5'd1, 16'h0, K_POLL, 435 + FRAME + 1, 16'h0, 1'b0, 1'b0));
        u_if.usr_r_w = 1'b0; u_if.usr_reg_add = 5'd9; u_if.usr_wdata = 16'h1234;
        u_if.usr_req = 1'b1;
        wait_until(435 + FRAME);
        chk("host_first_ack", u_if.usr_ack, 1'b1);
        u_if.usr_req = 1'b0;
        drain(50);
`else
        // No poller: the engine stays idle and link_up stays low.
        repeat (2 * POLL) @(posedge sys_clk);
        #1 chk("no_poll_link_up", link_up, 1'b0);
`endif

        // Reset in the middle of a host frame: no ack, init restarts.
        begin
            bit seen = 0;
            exp_q.push_back(mk(1'b0, 5'd5, 16'hBEEF, K_HOST, -1, 16'h0, 1'b0, 1'b0));
            u_if.usr_r_w = 1'b0; u_if.usr_reg_add = 5'd5; u_if.usr_wdata = 16'hBEEF;
            u_if.usr_req = 1'b1;
            for (int k = 0; k < 50 && !seen; k++) begin
                @(posedge sys_clk); #1;
                if (start_flag) seen = 1;
            end
            if (!seen) fail("abort_frame_start");
            repeat (3) @(posedge sys_clk);
            #3 sys_rst_n = 1'b0;
            #1 chk_reset_vals();
            u_if.usr_req = 1'b0;
            repeat (2) @(posedge sys_clk);
            release_reset();
            drain(100);
            chk("reinit_done", init_done, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
